// File: rtl/f_pc_gen_pkg.sv
// Shared encodings for the fetch-stage PC generator: next-PC selector codes,
// redirect classes (ordered by priority) and default address constants.
package f_pc_gen_pkg;

  localparam logic [2:0] NPC_BRANCH    = 3'd0;
  localparam logic [2:0] NPC_J         = 3'd1;
  localparam logic [2:0] NPC_JR        = 3'd2;
  localparam logic [2:0] NPC_NO_BRANCH = 3'd3;

  // Numeric order is the priority order; comparisons rely on it.
  typedef enum logic [1:0] {
    RC_NONE = 2'd0,
    RC_BR   = 2'd1,
    RC_ERET = 2'd2,
    RC_EXC  = 2'd3
  } redir_cls_e;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_HELD  = 1'b1
  } pend_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC     = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BYTES = 32'h0000_4000;

endpackage

// File: rtl/f_pc_gen_if.sv
// Bundle of D-stage redirect inputs, fetch handshake and F-stage outputs.
// Handshake: the fetch address advances in a cycle only when imem_ready=1 and F_stall=0.
interface f_pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              F_stall;
  logic              imem_ready;
  logic [ADDR_W-1:0] D_PC;
  logic [25:0]       D_imm26;
  logic [ADDR_W-1:0] reg_rs;
  logic [2:0]        NextPCType;
  logic              D_cmp_sig;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] EPC;
  logic [ADDR_W-1:0] F_PC;
  logic              F_adel;
  logic              F_flush;
  logic              pend_valid;

  modport master (
    output F_stall, imem_ready, D_PC, D_imm26, reg_rs, NextPCType,
           D_cmp_sig, exc_req, eret_req, EPC,
    input  F_PC, F_adel, F_flush, pend_valid
  );

  modport slave (
    input  F_stall, imem_ready, D_PC, D_imm26, reg_rs, NextPCType,
           D_cmp_sig, exc_req, eret_req, EPC,
    output F_PC, F_adel, F_flush, pend_valid
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational D-stage redirect target: branch / j / jr selection plus taken decode.
module pc_target_calc
  import f_pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [25:0]       d_imm26,
  input  logic [ADDR_W-1:0] reg_rs,
  input  logic [2:0]        next_pc_type,
  input  logic              d_cmp_sig,
  output logic              taken,
  output logic [ADDR_W-1:0] target
);
  logic signed [17:0] br_off18;
  logic [ADDR_W-1:0]  br_off;
  logic [ADDR_W-1:0]  br_tgt;
  logic [ADDR_W-1:0]  j_tgt;
  logic [27:0]        j_low;

  assign br_off18 = {d_imm26[15:0], 2'b00};
  assign br_off   = ADDR_W'(br_off18);
  assign br_tgt   = d_pc + ADDR_W'(4) + br_off;
  assign j_low    = {d_imm26, 2'b00};

  // Narrow PCs have no region bits above the 28-bit jump field.
  if (ADDR_W > 28) begin : g_j_wide
    assign j_tgt = {d_pc[ADDR_W-1:28], j_low};
  end else begin : g_j_narrow
    assign j_tgt = j_low[ADDR_W-1:0];
  end

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (next_pc_type)
      NPC_BRANCH: begin
        taken  = d_cmp_sig;
        target = br_tgt;
      end
      NPC_J: begin
        taken  = 1'b1;
        target = j_tgt;
      end
      NPC_JR: begin
        taken  = 1'b1;
        target = reg_rs;
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end
endmodule

// File: rtl/f_pc_gen.sv
// Fetch PC register with prioritised redirects and a one-entry pending-redirect
// buffer that holds a redirect until the fetch handshake lets the PC advance.
module f_pc_gen
  import f_pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_PC     = ADDR_W'(DEF_EXC_PC),
  parameter logic [ADDR_W-1:0] IMEM_BYTES = ADDR_W'(DEF_IMEM_BYTES)
) (
  input logic       clk,
  input logic       reset,
  f_pc_gen_if.slave bus
);
  localparam logic [ADDR_W:0] WIN_END = {1'b0, RESET_PC} + {1'b0, IMEM_BYTES};

  logic              calc_taken;
  logic [ADDR_W-1:0] calc_tgt;
  logic              advance;
  logic              req_wins;
  redir_cls_e        req_cls, load_cls;
  logic [ADDR_W-1:0] req_tgt;

  pend_state_e       pend_state_q, pend_state_d;
  redir_cls_e        pend_cls_q, pend_cls_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [ADDR_W-1:0] f_pc_q, f_pc_d;
  logic              f_flush_q, f_flush_d;
  logic              f_adel_q, f_adel_d;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .d_pc        (bus.D_PC),
    .d_imm26     (bus.D_imm26),
    .reg_rs      (bus.reg_rs),
    .next_pc_type(bus.NextPCType),
    .d_cmp_sig   (bus.D_cmp_sig),
    .taken       (calc_taken),
    .target      (calc_tgt)
  );

  always_comb begin
    advance = ~bus.F_stall & bus.imem_ready;
    req_cls = RC_NONE;
    req_tgt = '0;
    if (bus.exc_req) begin
      req_cls = RC_EXC;
      req_tgt = EXC_PC;
    end else if (bus.eret_req) begin
      req_cls = RC_ERET;
      req_tgt = bus.EPC;
    end else if (calc_taken) begin
      req_cls = RC_BR;
      req_tgt = calc_tgt;
    end
    // Equal rank replaces the held entry, so the newest request of a class wins.
    req_wins = (req_cls != RC_NONE) &&
               ((pend_state_q == PEND_EMPTY) || (req_cls >= pend_cls_q));

    f_pc_d       = f_pc_q;
    f_flush_d    = 1'b0;
    load_cls     = RC_NONE;
    pend_state_d = pend_state_q;
    pend_cls_d   = pend_cls_q;
    pend_tgt_d   = pend_tgt_q;
    if (advance) begin
      pend_state_d = PEND_EMPTY;
      pend_cls_d   = RC_NONE;
      if (req_wins) begin
        f_pc_d   = req_tgt;
        load_cls = req_cls;
      end else if (pend_state_q == PEND_HELD) begin
        f_pc_d   = pend_tgt_q;
        load_cls = pend_cls_q;
      end else begin
        f_pc_d = f_pc_q + ADDR_W'(4);
      end
      f_flush_d = (load_cls == RC_EXC) || (load_cls == RC_ERET);
    end else if (req_wins) begin
      pend_state_d = PEND_HELD;
      pend_cls_d   = req_cls;
      pend_tgt_d   = req_tgt;
    end

    f_adel_d = (f_pc_d[1:0] != 2'b00) || (f_pc_d < RESET_PC) ||
               ({1'b0, f_pc_d} >= WIN_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q       <= RESET_PC;
      f_flush_q    <= 1'b0;
      f_adel_q     <= 1'b0;
      pend_state_q <= PEND_EMPTY;
      pend_cls_q   <= RC_NONE;
      pend_tgt_q   <= '0;
    end else begin
      f_pc_q       <= f_pc_d;
      f_flush_q    <= f_flush_d;
      f_adel_q     <= f_adel_d;
      pend_state_q <= pend_state_d;
      pend_cls_q   <= pend_cls_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  assign bus.F_PC       = f_pc_q;
  assign bus.F_flush    = f_flush_q;
  assign bus.F_adel     = f_adel_q;
  assign bus.pend_valid = (pend_state_q == PEND_HELD);
endmodule
